udp_tx_frame_generator: RTL and testbench
=========================================

# udp_tx_frame_generator

Self-contained UDP/IPv4/Ethernet II transmit source that repeatedly emits fixed-format UDP datagrams on an MII transmit port. It computes a correct IPv4 header checksum and Ethernet FCS for every frame. It sits directly on the PHY MII TX pins and serves as a bring-up and example traffic source for the network peripheral stack. Every frame carries a 16-bit identification counter, so consecutive frames differ and checksum logic is exercised per frame.

## Interface
Parameters:
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC.
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC.
- SRC_IP, 32'hC0A8_010A, source IPv4 address (192.168.1.10).
- DST_IP, 32'hC0A8_01FF, destination IPv4 address (192.168.1.255).
- SRC_PORT, 16'd1234, UDP source port.
- DST_PORT, 16'd5000, UDP destination port.
- PAYLOAD_LEN, 18, UDP payload bytes. Legal range is 18..1472, so no Ethernet padding is ever needed.
- IFG_CYCLES, 24, idle clocks between frames (12 byte times).

Ports:
- udp_sys_clk  in  1  single clock; it is the MII TX clock and one nibble is output per rising edge.
- system_reset  in  1  asynchronous, active-low reset.
- mii_txd  out  4  TX nibble. This port and the two below form the phy_mii (mii_interface) TX group.
- mii_tx_en  out  1  transmit enable.
- mii_tx_er  out  1  transmit error; held at 0.

## Operation
- The FSM has five states: IFG → PREAMBLE → HEADER → PAYLOAD → FCS → IFG.
- IFG
  - tx_en=0 and txd=0 while a counter counts IFG_CYCLES clocks.
  - The IPv4 checksum for the next frame is computed during this state.
- PREAMBLE: 7 bytes of 0x55, then SFD 0xD5.
- HEADER is 42 bytes, in this order:
  - DST_MAC, then SRC_MAC, each MSB byte first.
  - EtherType 0x0800.
  - IPv4 header:
    - 0x45, 0x00.
    - total_len = 28+PAYLOAD_LEN.
    - ID = frame_id.
    - flags/frag = 0x4000.
    - TTL = 0x40, protocol = 0x11.
    - header checksum.
    - SRC_IP, DST_IP.
  - UDP header: SRC_PORT, DST_PORT, udp_len = 8+PAYLOAD_LEN, UDP checksum = 0x0000 (disabled).
  - All multi-byte fields are sent big-endian.
- PAYLOAD: byte i = i[7:0] for i = 0..PAYLOAD_LEN-1.
- FCS
  - CRC-32 covers DST_MAC through the last payload byte. Preamble and SFD are excluded.
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - The 4 FCS bytes are sent least-significant byte first.
- Nibble order: for every byte, the low nibble is sent on the first cycle and the high nibble on the second.
- IPv4 checksum
  - One's-complement sum of the ten 16-bit header words, with the checksum word taken as 0.
  - End-around carries are folded until the sum fits in 16 bits; the result is then inverted.
  - The value is computed from the 16-bit ID of the upcoming frame.
- frame_id is 16 bits, starts at 0 and increments after each FCS completes. It wraps from 0xFFFF to 0x0000.
- The CRC is updated per nibble (4-bit serial) or per byte; either is acceptable if the output matches.

## Timing
- Reset (system_reset=0), asynchronous assertion:
  - mii_txd=0, mii_tx_en=0, mii_tx_er=0.
  - FSM goes to IFG with its counter cleared, frame_id=0, CRC state cleared.
- Reset mid-frame: the frame aborts immediately with tx_en=0. After release, the next frame restarts from preamble with ID 0.
- All outputs are registered; there are no combinational paths to outputs.
- After reset release, the first tx_en=1 cycle follows exactly IFG_CYCLES clocks with tx_en=0.
- tx_en stays high continuously for 2×(54+PAYLOAD_LEN) clocks, which is 144 clocks at the defaults. It then drops for exactly IFG_CYCLES clocks.
- Frame period is 2×(54+PAYLOAD_LEN)+IFG_CYCLES clocks, which is 168 at the defaults.
- txd is 0 whenever tx_en=0. mii_tx_er is 0 always.

## Test plan
- Hold reset low for 10 clocks → tx_en=0, txd=0, tx_er=0 throughout. Release reset → first tx_en=1 after exactly 24 clocks.
- Capture frame 0 at defaults → nibbles 0x5×15, 0xD, then byte 0xD5. The frame is 72 bytes (144 tx_en clocks) followed by a 24-clock gap.
- Frame 0 IPv4 header → bytes 45 00 00 2E 00 00 40 00 40 11 B6 65 C0 A8 01 0A C0 A8 01 FF. Frame 1 → ID 0x0001, checksum 0xB664.
- UDP header of frame 0 → 04 D2 13 88 00 1A 00 00. Payload → bytes 0x00..0x11.
- Recompute CRC-32 over bytes 8..67 of frames 0–3 → each matches the transmitted FCS (LSB first). The residue over data plus FCS is 0xDEBB20E3.
- Assert reset at clock 60 of a frame → tx_en=0 within the same cycle. After release, the next frame has ID 0 and checksum 0xB665.

Source files
------------

// File: rtl/udp_tx_frame_generator.sv
// Free-running UDP/IPv4/Ethernet II frame source driving the MII TX pins.
// Each frame carries an incrementing 16-bit IP ID, a live header checksum and a CRC-32 FCS.
module udp_tx_frame_generator #(
   parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
   parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
   parameter logic [31:0] SRC_IP      = 32'hC0A8_010A,
   parameter logic [31:0] DST_IP      = 32'hC0A8_01FF,
   parameter logic [15:0] SRC_PORT    = 16'd1234,
   parameter logic [15:0] DST_PORT    = 16'd5000,
   parameter int          PAYLOAD_LEN = 18,
   parameter int          IFG_CYCLES  = 24
) (
   input  logic       udp_sys_clk,
   input  logic       system_reset,
   output logic [3:0] mii_txd,
   output logic       mii_tx_en,
   output logic       mii_tx_er
);

   // state    | meaning
   // S_IFG    | idle gap, tx_en low, next IPv4 checksum computed
   // S_PRE    | 7 x 0x55 preamble then 0xD5 SFD
   // S_HEADER | 42 bytes Ethernet + IPv4 + UDP header
   // S_PAYLOAD| incrementing payload bytes
   // S_FCS    | 4 CRC-32 bytes, LSB first
   typedef enum logic [2:0] {S_IFG, S_PRE, S_HEADER, S_PAYLOAD, S_FCS} state_t;

   localparam logic [15:0] TOTAL_LEN = 16'(28 + PAYLOAD_LEN);
   localparam logic [15:0] UDP_LEN   = 16'(8 + PAYLOAD_LEN);
   localparam logic [10:0] IFG_TC    = 11'(IFG_CYCLES - 1);
   localparam logic [10:0] PAY_TC    = 11'(PAYLOAD_LEN - 1);

   state_t      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic        nib_q, nib_d;
   logic [15:0] frame_id_q, frame_id_d;
   logic [15:0] csum_q, csum_d;
   logic [31:0] crc_q, crc_d;
   logic [3:0]  txd_q, txd_d;
   logic        tx_en_q, tx_en_d;

   logic [335:0] hdr_w;
   logic [5:0]   hdr_rev;
   logic [31:0]  fcs_w;
   logic [7:0]   tx_byte;
   logic [31:0]  sum_w;
   logic [16:0]  fold_w;
   logic [15:0]  csum_calc;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      sum_w = 32'h4500 + {16'h0, TOTAL_LEN} + {16'h0, frame_id_q} + 32'h4000 + 32'h4011
            + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
            + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
      fold_w    = {1'b0, sum_w[15:0]} + {1'b0, sum_w[31:16]};
      csum_calc = ~(fold_w[15:0] + {15'h0, fold_w[16]});
   end

   assign hdr_w = {DST_MAC, SRC_MAC, 16'h0800,
                   8'h45, 8'h00, TOTAL_LEN, frame_id_q, 16'h4000, 8'h40, 8'h11, csum_q,
                   SRC_IP, DST_IP,
                   SRC_PORT, DST_PORT, UDP_LEN, 16'h0000};
   assign hdr_rev = 6'd41 - cnt_q[5:0];
   assign fcs_w   = ~crc_q;

   always_comb begin
      tx_byte = 8'h00;
      case (state_q)
         S_PRE:     tx_byte = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
         S_HEADER:  tx_byte = hdr_w[{hdr_rev, 3'b000} +: 8];
         S_PAYLOAD: tx_byte = cnt_q[7:0];
         S_FCS:     tx_byte = fcs_w[{cnt_q[1:0], 3'b000} +: 8];
         default:   tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      nib_d      = 1'b0;
      frame_id_d = frame_id_q;
      csum_d     = csum_q;
      crc_d      = crc_q;
      tx_en_d    = 1'b0;
      txd_d      = 4'h0;

      if (state_q != S_IFG) begin
         nib_d   = ~nib_q;
         tx_en_d = 1'b1;
         txd_d   = nib_q ? tx_byte[7:4] : tx_byte[3:0];
         if (nib_q) cnt_d = cnt_q + 11'd1;
      end

      case (state_q)
         S_IFG: begin
            crc_d  = 32'hFFFF_FFFF;
            csum_d = csum_calc;
            if (cnt_q == IFG_TC) begin
               state_d = S_PRE;
               cnt_d   = 11'd0;
            end else begin
               cnt_d = cnt_q + 11'd1;
            end
         end
         S_PRE: begin
            if (nib_q && cnt_q == 11'd7) begin
               state_d = S_HEADER;
               cnt_d   = 11'd0;
            end
         end
         S_HEADER: begin
            if (!nib_q) crc_d = crc_byte(crc_q, tx_byte);
            if (nib_q && cnt_q == 11'd41) begin
               state_d = S_PAYLOAD;
               cnt_d   = 11'd0;
            end
         end
         S_PAYLOAD: begin
            if (!nib_q) crc_d = crc_byte(crc_q, tx_byte);
            if (nib_q && cnt_q == PAY_TC) begin
               state_d = S_FCS;
               cnt_d   = 11'd0;
            end
         end
         S_FCS: begin
            if (nib_q && cnt_q == 11'd3) begin
               state_d    = S_IFG;
               cnt_d      = 11'd0;
               frame_id_d = frame_id_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IFG;
            cnt_d   = 11'd0;
         end
      endcase
   end

   always_ff @(posedge udp_sys_clk or negedge system_reset) begin
      if (!system_reset) begin
         state_q    <= S_IFG;
         cnt_q      <= 11'd0;
         nib_q      <= 1'b0;
         frame_id_q <= 16'h0000;
         csum_q     <= 16'h0000;
         crc_q      <= 32'h0000_0000;
         txd_q      <= 4'h0;
         tx_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         nib_q      <= nib_d;
         frame_id_q <= frame_id_d;
         csum_q     <= csum_d;
         crc_q      <= crc_d;
         txd_q      <= txd_d;
         tx_en_q    <= tx_en_d;
      end
   end

   assign mii_txd   = txd_q;
   assign mii_tx_en = tx_en_q;
   assign mii_tx_er = 1'b0;

endmodule

// File: tb/tb_udp_tx_frame_generator.sv
// Directed bench for udp_tx_frame_generator: reset behaviour, frame timing, header, payload and FCS.
module tb_udp_tx_frame_generator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] txd;
   logic       tx_en;
   logic       tx_er;

   always #5 clk = ~clk;

   udp_tx_frame_generator dut (
      .udp_sys_clk (clk),
      .system_reset(rst_n),
      .mii_txd     (txd),
      .mii_tx_en   (tx_en),
      .mii_tx_er   (tx_er)
   );

   int         checks = 0;
   int         fails  = 0;
   logic [7:0] frm [0:1023];
   int         nibs;
   int         gap;
   logic       bad_idle;
   logic       bad_er;
   logic       timeout;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 8; b++) begin
         if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   // Hand-written frame image; checksum is 0xB665 for ID 0 and drops by one per ID step.
   function automatic logic [7:0] exp_byte(input int fid, input int i);
      logic [7:0]  h [0:41];
      logic [15:0] id;
      logic [15:0] cs;
      id = fid[15:0];
      cs = 16'hB665 - id;
      h = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
            8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h08, 8'h00,
            8'h45, 8'h00, 8'h00, 8'h2E, id[15:8], id[7:0], 8'h40, 8'h00,
            8'h40, 8'h11, cs[15:8], cs[7:0],
            8'hC0, 8'hA8, 8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'hFF,
            8'h04, 8'hD2, 8'h13, 8'h88, 8'h00, 8'h1A, 8'h00, 8'h00};
      if (i < 7)       return 8'h55;
      else if (i == 7) return 8'hD5;
      else if (i < 50) return h[i-8];
      else             return 8'(i - 50);
   endfunction

   task automatic capture(input int idle0);
      int         idle;
      logic [3:0] lo;
      idle = idle0; bad_idle = 1'b0; bad_er = 1'b0; timeout = 1'b0; nibs = 0; lo = 4'h0;
      @(negedge clk);
      while (tx_en !== 1'b1 && idle < 1000) begin
         if (txd !== 4'h0)  bad_idle = 1'b1;
         if (tx_er !== 1'b0) bad_er  = 1'b1;
         idle++;
         @(negedge clk);
      end
      if (tx_en !== 1'b1) timeout = 1'b1;
      gap = idle;
      while (tx_en === 1'b1 && nibs < 2000) begin
         if (tx_er !== 1'b0) bad_er = 1'b1;
         if (nibs[0] == 1'b0) lo = txd;
         else                 frm[nibs>>1] = {txd, lo};
         nibs++;
         @(negedge clk);
      end
   endtask

   task automatic check_frame(input int fid);
      logic [31:0] c;
      logic [31:0] fcs_exp;
      chk($sformatf("f%0d_timeout", fid), 32'(timeout), 32'd0);
      chk($sformatf("f%0d_gap", fid), 32'(gap), 32'd24);
      chk($sformatf("f%0d_len_nibbles", fid), 32'(nibs), 32'd144);
      chk($sformatf("f%0d_idle_txd", fid), 32'(bad_idle), 32'd0);
      chk($sformatf("f%0d_tx_er", fid), 32'(bad_er), 32'd0);
      for (int i = 0; i < 68; i++)
         chk($sformatf("f%0d_byte%0d", fid, i), 32'(frm[i]), 32'(exp_byte(fid, i)));
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 68; i++) c = crc_upd(c, exp_byte(fid, i));
      fcs_exp = ~c;
      chk($sformatf("f%0d_fcs", fid), {frm[71], frm[70], frm[69], frm[68]}, fcs_exp);
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 72; i++) c = crc_upd(c, frm[i]);
      chk($sformatf("f%0d_residue", fid), c, 32'hDEBB_20E3);
   endtask

   initial begin
      int w;
      rst_n = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("reset_outputs", 32'({tx_en, tx_er, txd}), 32'd0);
      end
      rst_n = 1'b1;

      capture(0);
      check_frame(0);
      for (int f = 1; f < 4; f++) begin
         capture(1);
         check_frame(f);
      end

      w = 1;
      @(negedge clk);
      while (tx_en !== 1'b1 && w < 1000) begin
         w++;
         @(negedge clk);
      end
      chk("abort_wait_timeout", 32'(tx_en !== 1'b1), 32'd0);
      repeat (59) @(negedge clk);
      chk("abort_pre_txen", 32'(tx_en), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("abort_outputs", 32'({tx_en, tx_er, txd}), 32'd0);
      repeat (5) begin
         @(negedge clk);
         chk("abort_held", 32'({tx_en, tx_er, txd}), 32'd0);
      end
      rst_n = 1'b1;
      capture(0);
      check_frame(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
